// File: rtl/arisco_pkg.sv
// arisco_pkg: shared opcodes, sequencer state type and fixed instruction words.
// No ports. Helper op_supported() decides whether an instruction word's opcode is
// one the datapath implements; it is used only when FETCH_SEQ_TRAP_EN is defined.
package arisco_pkg;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [31:0] INSN_NOP    = 32'h0000_0013;
   localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} seq_state_t;
   // Only ECALL/EBREAK are legal SYSTEM words; anything else in that opcode traps.
   function automatic logic op_supported(input logic [31:0] insn);
      case (insn[6:0])
         OP_R, OP_I, OP_LOAD, OP_STORE, OP_LUI, OP_JAL: return 1'b1;
         OP_SYSTEM: return insn == INSN_ECALL || insn == INSN_EBREAK;
         default: return 1'b0;
      endcase
   endfunction
endpackage

// File: rtl/fetch_sequencer_next_pc.sv
// next_pc_unit: combinational next-PC candidates for the current instruction.
// Inputs : pc, instruction
// Outputs: pc_plus4 (pc+4 mod 2^32), jal_target (pc + J-immediate),
//          is_jal (opcode is JAL), misaligned (jal_target not word aligned)
module next_pc_unit
   import arisco_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] instruction,
   output logic [31:0] pc_plus4,
   output logic [31:0] jal_target,
   output logic        is_jal,
   output logic        misaligned
);
   logic [31:0] j_imm;
   assign j_imm      = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                        instruction[20], instruction[30:21], 1'b0};
   assign pc_plus4   = pc + 32'd4;
   assign jal_target = pc + j_imm;
   assign is_jal     = instruction[6:0] == OP_JAL;
   assign misaligned = |jal_target[1:0];
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle PC owner that fetches over req/ack and strobes execution.
// Ports: clk, reset (sync, active-high), run (permit new fetch);
//        imem_req/imem_addr/imem_ack/imem_rdata (instruction fetch handshake);
//        instruction, pc, pc_next (to datapath); exec_en (one-cycle commit strobe);
//        halted, fault (sticky status); retired (committed instruction count).
// Build option: define FETCH_SEQ_TRAP_EN to fault on opcodes the datapath lacks.
module fetch_sequencer
   import arisco_pkg::*;
#(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction,
   output logic [31:0] pc,
   output logic [31:0] pc_next,
   output logic        exec_en,
   output logic        halted,
   output logic        fault,
   output logic [31:0] retired
);
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
   seq_state_t  state_q;
   logic [31:0] pc_q, pc_d, insn_q, retired_q;
   logic [7:0]  wait_q;
   logic        req_q, halted_q, fault_q;
   logic [31:0] pc_plus4, jal_target;
   logic        is_jal, misaligned, is_sys, bad_op, commit;
   next_pc_unit u_next_pc (
      .pc          (pc_q),
      .instruction (insn_q),
      .pc_plus4    (pc_plus4),
      .jal_target  (jal_target),
      .is_jal      (is_jal),
      .misaligned  (misaligned)
   );
   assign is_sys = insn_q == INSN_ECALL || insn_q == INSN_EBREAK;
`ifdef FETCH_SEQ_TRAP_EN
   assign bad_op = !op_supported(insn_q);
`else
   assign bad_op = 1'b0;
`endif
   // An instruction commits unless it halts the core (system call, trap, bad jump).
   assign commit = !is_sys && !bad_op && !(is_jal && misaligned);
   assign pc_d   = is_jal ? jal_target : pc_plus4;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         insn_q    <= INSN_NOP;
         retired_q <= '0;
         wait_q    <= '0;
         req_q     <= 1'b0;
         halted_q  <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE:
               if (run) begin
                  state_q <= S_FETCH;
                  req_q   <= 1'b1;
               end
            S_FETCH:
               // Ack is checked first so a response on the final wait cycle still wins.
               if (imem_ack) begin
                  insn_q  <= imem_rdata;
                  wait_q  <= '0;
                  req_q   <= 1'b0;
                  state_q <= S_EXEC;
               end else if (wait_q == WAIT_LAST) begin
                  req_q    <= 1'b0;
                  halted_q <= 1'b1;
                  fault_q  <= 1'b1;
                  state_q  <= S_HALT;
               end else begin
                  wait_q <= wait_q + 8'd1;
               end
            S_EXEC:
               if (commit) begin
                  pc_q      <= pc_d;
                  retired_q <= retired_q + 32'd1;
                  req_q     <= run;
                  state_q   <= run ? S_FETCH : S_IDLE;
               end else begin
                  halted_q <= 1'b1;
                  fault_q  <= !is_sys;
                  state_q  <= S_HALT;
               end
            default: ;
         endcase
      end
   end
   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign instruction = insn_q;
   assign pc          = pc_q;
   assign pc_next     = pc_plus4;
   assign exec_en     = state_q == S_EXEC && commit;
   assign halted      = halted_q;
   assign fault       = fault_q;
   assign retired     = retired_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed stimulus with a behavioural model checked every cycle.
module tb_fetch_sequencer;
   localparam int          TO  = 16;
   localparam logic [31:0] RPC = 32'h0000_0000;
   localparam int P_IDLE = 0, P_FETCH = 1, P_EXEC = 2, P_HALT = 3;
   logic        clk = 1'b0, reset = 1'b1, run = 1'b0, imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'hDEAD_BEEF;
   logic        imem_req, exec_en, halted, fault;
   logic [31:0] imem_addr, instruction, pc, pc_next, retired;
   always #5 clk = ~clk;
   fetch_sequencer dut (
      .clk(clk), .reset(reset), .run(run),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instruction(instruction), .pc(pc), .pc_next(pc_next), .exec_en(exec_en),
      .halted(halted), .fault(fault), .retired(retired)
   );
   logic [31:0] mem [logic [31:0]];
   int   ack_delay = 0;
   logic stray = 1'b0;
   int   passed = 0, checks = 0;
   typedef struct {
      logic        valid;
      int          phase;
      logic [31:0] pc, inst, ret;
      int          missed;
      logic        halted, fault;
   } model_t;
   model_t m = '{valid: 1'b0, phase: 0, pc: '0, inst: '0, ret: '0, missed: 0, halted: 1'b0, fault: 1'b0};
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
   endtask
   function automatic logic [31:0] jtarget(input logic [31:0] p, input logic [31:0] w);
      logic [20:0] off;
      off = {w[31], w[19:12], w[20], w[30:21], 1'b0};
      return p + 32'($signed(off));
   endfunction
   function automatic logic is_sys(input logic [31:0] w);
      return w == 32'h0000_0073 || w == 32'h0010_0073;
   endfunction
   function automatic logic known_op(input logic [31:0] w);
      logic [6:0] o;
      o = w[6:0];
      return o == 7'h33 || o == 7'h13 || o == 7'h03 || o == 7'h23 || o == 7'h37 || o == 7'h6F || is_sys(w);
   endfunction
   function automatic logic commits(input model_t s);
      logic [31:0] t;
      t = jtarget(s.pc, s.inst);
      if (is_sys(s.inst)) return 1'b0;
`ifdef FETCH_SEQ_TRAP_EN
      if (!known_op(s.inst)) return 1'b0;
`endif
      if (s.inst[6:0] == 7'h6F && t[1:0] != 2'b00) return 1'b0;
      return 1'b1;
   endfunction
   function automatic model_t step(input model_t s, input logic rst, input logic go,
                                   input logic ack, input logic [31:0] rd);
      model_t n;
      n = s;
      if (rst) return '{valid: 1'b1, phase: P_IDLE, pc: RPC, inst: 32'h13, ret: '0, missed: 0, halted: 1'b0, fault: 1'b0};
      if (s.phase == P_IDLE && go) n.phase = P_FETCH;
      else if (s.phase == P_FETCH && ack) begin
         n.inst = rd;
         n.missed = 0;
         n.phase = P_EXEC;
      end else if (s.phase == P_FETCH) begin
         n.missed = s.missed + 1;
         if (n.missed >= TO) begin
            n.phase = P_HALT;
            n.halted = 1'b1;
            n.fault = 1'b1;
         end
      end else if (s.phase == P_EXEC && commits(s)) begin
         n.pc = s.inst[6:0] == 7'h6F ? jtarget(s.pc, s.inst) : s.pc + 32'd4;
         n.ret = s.ret + 32'd1;
         n.phase = go ? P_FETCH : P_IDLE;
      end else if (s.phase == P_EXEC) begin
         n.phase = P_HALT;
         n.halted = 1'b1;
         n.fault = !is_sys(s.inst);
      end
      return n;
   endfunction
   always @(posedge clk) m <= step(m, reset, run, imem_ack, imem_rdata);
   initial forever begin
      @(negedge clk);
      if (m.valid) begin
         chk("imem_req", {31'd0, imem_req}, {31'd0, m.phase == P_FETCH});
         if (m.phase == P_FETCH) chk("imem_addr", imem_addr, m.pc);
         chk("pc", pc, m.pc);
         chk("pc_next", pc_next, m.pc + 32'd4);
         chk("instruction", instruction, m.inst);
         chk("exec_en", {31'd0, exec_en}, {31'd0, m.phase == P_EXEC && commits(m)});
         chk("halted", {31'd0, halted}, {31'd0, m.halted});
         chk("fault", {31'd0, fault}, {31'd0, m.fault});
         chk("retired", retired, m.ret);
      end
   end
   initial begin
      int waitc;
      waitc = 0;
      forever begin
         @(negedge clk);
         if (imem_req && waitc == ack_delay) begin
            imem_ack = 1'b1;
            imem_rdata = mem.exists(imem_addr) ? mem[imem_addr] : 32'h0000_0013;
            waitc = 0;
         end else if (imem_req) begin
            imem_ack = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            waitc++;
         end else begin
            imem_ack = stray;
            imem_rdata = 32'h0050_0093;
            waitc = 0;
         end
      end
   end
   task automatic do_reset();
      reset = 1'b1;
      run = 1'b0;
      stray = 1'b0;
      ack_delay = 0;
      mem.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask
   task automatic wait_halt(input string name);
      int n;
      n = 0;
      while (!halted && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(name, {31'd0, halted}, 32'd1);
   endtask
   task automatic count_req(input string name, input int exp);
      int n;
      n = 0;
      while (!imem_req && n < 10) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (imem_req && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk(name, n, exp);
   endtask
   initial begin
      int n;
      do_reset();
      chk("rst_pc", pc, 32'h0);
      chk("rst_inst", instruction, 32'h13);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_retired", retired, 32'd0);
      // addi with same-cycle ack
      mem[32'h0] = 32'h0050_0093;
      run = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t1_exec_en", {31'd0, exec_en}, 32'd1);
      chk("t1_pc_next", pc_next, 32'h4);
      run = 1'b0;
      @(negedge clk);
      chk("t1_pc", pc, 32'h4);
      chk("t1_retired", retired, 32'd1);
      chk("t1_idle_req", {31'd0, imem_req}, 32'd0);
      // JAL x1,+8 at 0x10, then ECALL at 0x18 and stray acks while halted
      do_reset();
      mem[32'h10] = 32'h0080_00EF;
      mem[32'h18] = 32'h0000_0073;
      run = 1'b1;
      n = 0;
      while (!(exec_en && pc == 32'h10) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("t2_jal_exec", {31'd0, exec_en}, 32'd1);
      chk("t2_pc_next", pc_next, 32'h14);
      @(negedge clk);
      chk("t2_target_addr", imem_addr, 32'h18);
      wait_halt("t2_halt");
      chk("t2_fault", {31'd0, fault}, 32'd0);
      chk("t2_retired", retired, 32'd5);
      chk("t2_pc", pc, 32'h18);
      stray = 1'b1;
      repeat (5) @(negedge clk);
      chk("t2_stray_retired", retired, 32'd5);
      chk("t2_stray_req", {31'd0, imem_req}, 32'd0);
      // ack after 3 wait cycles, then a fetch that never completes
      do_reset();
      ack_delay = 3;
      run = 1'b1;
      count_req("t3_req_cycles", 4);
      ack_delay = 99;
      count_req("t3_timeout_cycles", 16);
      chk("t3_halted", {31'd0, halted}, 32'd1);
      chk("t3_fault", {31'd0, fault}, 32'd1);
      chk("t3_pc", pc, 32'h4);
      // ack on the final allowed cycle wins over the timeout
      do_reset();
      ack_delay = 15;
      run = 1'b1;
      count_req("t3b_req_cycles", 16);
      chk("t3b_exec_en", {31'd0, exec_en}, 32'd1);
      chk("t3b_fault", {31'd0, fault}, 32'd0);
      run = 1'b0;
      // EBREAK halts without fault
      do_reset();
      mem[32'h0] = 32'h0010_0073;
      run = 1'b1;
      wait_halt("t4_halt");
      chk("t4_fault", {31'd0, fault}, 32'd0);
      chk("t4_retired", retired, 32'd0);
      // run dropped mid-fetch, then reset mid-fetch
      do_reset();
      ack_delay = 3;
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      repeat (8) @(negedge clk);
      chk("t5_retired", retired, 32'd1);
      chk("t5_req", {31'd0, imem_req}, 32'd0);
      chk("t5_pc", pc, 32'h4);
      ack_delay = 99;
      run = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      run = 1'b0;
      chk("t5_rst_req", {31'd0, imem_req}, 32'd0);
      chk("t5_rst_pc", pc, RPC);
      // unknown opcode
      do_reset();
      mem[32'h0] = 32'h0000_0007;
      run = 1'b1;
      repeat (2) @(negedge clk);
      run = 1'b0;
`ifdef FETCH_SEQ_TRAP_EN
      chk("t6_exec_en", {31'd0, exec_en}, 32'd0);
      @(negedge clk);
      chk("t6_fault", {31'd0, fault}, 32'd1);
`else
      chk("t6_exec_en", {31'd0, exec_en}, 32'd1);
      @(negedge clk);
      chk("t6_pc", pc, 32'h4);
`endif
      // JAL to a misaligned target
      do_reset();
      mem[32'h0] = 32'h0020_006F;
      run = 1'b1;
      wait_halt("t7_halt");
      chk("t7_fault", {31'd0, fault}, 32'd1);
      chk("t7_retired", retired, 32'd0);
      chk("t7_pc", pc, 32'h0);
      // JAL -4 from 0 wraps to 0xFFFFFFFC; pc+4 there wraps to 0
      do_reset();
      mem[32'h0] = 32'hFFDF_F06F;
      run = 1'b1;
      n = 0;
      while (!(exec_en && pc == 32'hFFFF_FFFC) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("t8_wrap_pc", pc, 32'hFFFF_FFFC);
      chk("t8_pc_next", pc_next, 32'h0);
      run = 1'b0;
      @(negedge clk);
      chk("t8_pc_after", pc, 32'h0);
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
